// File: rtl/link_anchor_rsp.sv
// Far-end responder of a dist_sim link ring: terminates frames addressed to this node
// into a token FIFO with sequence checking, forwards foreign frames, and returns credit acks.
module link_anchor_rsp #(
  parameter int unsigned ID     = 0,
  parameter int unsigned DEPTH  = 4,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wen_down,
  input  logic [31:0] i_token_down,
  input  logic [31:0] i_clk_cnt_down,
  input  logic [31:0] i_id_down,
  output logic        o_wen_up,
  output logic [31:0] o_token_up,
  output logic [31:0] o_clk_cnt_up,
  output logic [31:0] o_id_up,
  output logic        o_rx_valid,
  output logic [31:0] o_rx_token,
  input  logic        i_rx_ready,
  output logic        o_err_seq,
  output logic [15:0] o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] token_up_q, token_up_d;
  logic [31:0] clk_cnt_up_q, clk_cnt_up_d;
  logic [31:0] id_up_q, id_up_d;

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] credit_q, credit_d;
  logic [31:0] last_cnt_q;
  logic        seq_valid_q;
  logic        err_seq_q;
  logic [15:0] drop_cnt_q;
  logic [31:0] clk_cnt_q;

  logic        isMine, isForeign;
  logic        fifoEmpty, fifoFull;
  logic        doPop, seqOk, accept, drop;
  logic [31:0] seqDiff;

  assign isMine    = i_wen_down && (i_id_down == 32'(ID));
  assign isForeign = i_wen_down && (i_id_down != 32'(ID));

  assign fifoEmpty = (wr_ptr_q == rd_ptr_q);
  assign fifoFull  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign doPop     = !fifoEmpty && i_rx_ready;

  // Signed difference keeps the ordering check valid across the 32-bit stamp wrap.
  assign seqDiff = i_clk_cnt_down - last_cnt_q;
  assign seqOk   = !seq_valid_q || (!seqDiff[31] && (seqDiff != 32'd0));
  assign accept  = isMine && seqOk && (!fifoFull || doPop);
  assign drop    = isMine && !accept;

  always_comb begin
    state_d      = IDLE;
    token_up_d   = token_up_q;
    clk_cnt_up_d = clk_cnt_up_q;
    id_up_d      = id_up_q;
    credit_d     = credit_q + CW'(accept);
    if (isForeign && FWD_EN) begin
      state_d      = FWD;
      token_up_d   = i_token_down;
      clk_cnt_up_d = i_clk_cnt_down;
      id_up_d      = i_id_down;
    end else if (credit_q != '0) begin
      state_d      = ACK;
      token_up_d   = 32'(credit_q);
      clk_cnt_up_d = clk_cnt_q;
      id_up_d      = 32'(ID);
      credit_d     = CW'(accept);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      token_up_q   <= '0;
      clk_cnt_up_q <= '0;
      id_up_q      <= '0;
      credit_q     <= '0;
      clk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      token_up_q   <= token_up_d;
      clk_cnt_up_q <= clk_cnt_up_d;
      id_up_q      <= id_up_d;
      credit_q     <= credit_d;
      clk_cnt_q    <= clk_cnt_q + 32'd1;
    end
  end

  // The storage is cleared too so the head token reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q[AW-1:0]] <= i_token_down;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (doPop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_cnt_q  <= '0;
      seq_valid_q <= 1'b0;
      err_seq_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (accept) begin
        last_cnt_q  <= i_clk_cnt_down;
        seq_valid_q <= 1'b1;
      end
      if (isMine && !seqOk) err_seq_q <= 1'b1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_wen_up     = (state_q != IDLE);
  assign o_token_up   = token_up_q;
  assign o_clk_cnt_up = clk_cnt_up_q;
  assign o_id_up      = id_up_q;
  assign o_rx_valid   = !fifoEmpty;
  assign o_rx_token   = mem_q[rd_ptr_q[AW-1:0]];
  assign o_err_seq    = err_seq_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_link_anchor_rsp.sv
// Directed self-checking bench for link_anchor_rsp (ID=0, DEPTH=4, FWD_EN=1).
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_link_anchor_rsp;

  logic        clk;
  logic        rstn;
  logic        wenDown;
  logic [31:0] tokenDown;
  logic [31:0] clkCntDown;
  logic [31:0] idDown;
  logic        wenUp;
  logic [31:0] tokenUp;
  logic [31:0] clkCntUp;
  logic [31:0] idUp;
  logic        rxValid;
  logic [31:0] rxToken;
  logic        rxReady;
  logic        errSeq;
  logic [15:0] dropCnt;

  int checks = 0;
  int errors = 0;
  int ackTotal;

  link_anchor_rsp #(.ID(0), .DEPTH(4), .FWD_EN(1'b1)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_wen_down    (wenDown),
    .i_token_down  (tokenDown),
    .i_clk_cnt_down(clkCntDown),
    .i_id_down     (idDown),
    .o_wen_up      (wenUp),
    .o_token_up    (tokenUp),
    .o_clk_cnt_up  (clkCntUp),
    .o_id_up       (idUp),
    .o_rx_valid    (rxValid),
    .o_rx_token    (rxToken),
    .i_rx_ready    (rxReady),
    .o_err_seq     (errSeq),
    .o_drop_cnt    (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sum of credit carried by every ack frame (id 0) seen up-link since the last reset.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) ackTotal <= 0;
    else if (wenUp && idUp == 32'd0) ackTotal <= ackTotal + int'(tokenUp);
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of down-link input, then return on the next falling edge.
  task automatic applyStimulus(input logic wen, input logic [31:0] id, input logic [31:0] tok,
                               input logic [31:0] stamp);
    wenDown    = wen;
    idDown     = id;
    tokenDown  = tok;
    clkCntDown = stamp;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic applyReset();
    wenDown = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; wenDown = 1'b0; tokenDown = '0; clkCntDown = '0; idDown = '0; rxReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wen_up", 32'(wenUp), 32'd0);
    checkOutput("rst_token_up", tokenUp, 32'd0);
    checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("rst_rx_token", rxToken, 32'd0);
    checkOutput("rst_err_seq", 32'(errSeq), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
    rstn = 1'b1;

    $display("[TB] basic MINE frames");
    applyStimulus(1'b1, 32'd0, 32'hA1, 32'd10);
    checkOutput("m1_rx_valid", 32'(rxValid), 32'd1);
    checkOutput("m1_rx_token", rxToken, 32'hA1);
    applyStimulus(1'b1, 32'd0, 32'hA2, 32'd11);
    checkOutput("m2_rx_token", rxToken, 32'hA2);
    checkOutput("m2_ack_wen", 32'(wenUp), 32'd1);
    checkOutput("m2_ack_id", idUp, 32'd0);
    checkOutput("m2_ack_credit", tokenUp, 32'd1);
    idleCycles(3);
    #1;
    checkOutput("m_ack_total", 32'(ackTotal), 32'd2);
    checkOutput("m_rx_drained", 32'(rxValid), 32'd0);

    $display("[TB] FOREIGN forward");
    applyStimulus(1'b1, 32'd5, 32'hDEAD, 32'd7);
    checkOutput("f_wen", 32'(wenUp), 32'd1);
    checkOutput("f_id", idUp, 32'd5);
    checkOutput("f_token", tokenUp, 32'hDEAD);
    checkOutput("f_stamp", clkCntUp, 32'd7);
    checkOutput("f_no_push", 32'(rxValid), 32'd0);
    idleCycles(1);
    checkOutput("f_idle_wen", 32'(wenUp), 32'd0);
    checkOutput("f_idle_hold", tokenUp, 32'hDEAD);

    $display("[TB] sequence error");
    applyStimulus(1'b1, 32'd0, 32'h20, 32'd20);
    checkOutput("s20_err", 32'(errSeq), 32'd0);
    applyStimulus(1'b1, 32'd0, 32'h15, 32'd15);
    checkOutput("s15_err", 32'(errSeq), 32'd1);
    checkOutput("s15_drop", 32'(dropCnt), 32'd1);
    applyStimulus(1'b1, 32'd0, 32'h21, 32'd21);
    checkOutput("s21_rx_valid", 32'(rxValid), 32'd1);
    checkOutput("s21_rx_token", rxToken, 32'h21);
    checkOutput("s21_drop", 32'(dropCnt), 32'd1);
    checkOutput("s21_err_sticky", 32'(errSeq), 32'd1);
    idleCycles(3);

    $display("[TB] stamp wrap");
    applyReset();
    applyStimulus(1'b1, 32'd0, 32'hE1, 32'hFFFF_FFFE);
    checkOutput("w1_rx_token", rxToken, 32'hE1);
    applyStimulus(1'b1, 32'd0, 32'hE2, 32'hFFFF_FFFF);
    checkOutput("w2_rx_token", rxToken, 32'hE2);
    applyStimulus(1'b1, 32'd0, 32'hE3, 32'h0000_0000);
    checkOutput("w3_rx_token", rxToken, 32'hE3);
    checkOutput("w_err", 32'(errSeq), 32'd0);
    checkOutput("w_drop", 32'(dropCnt), 32'd0);
    idleCycles(3);

    $display("[TB] FIFO full back-pressure");
    rxReady = 1'b0;
    applyReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'd0, 32'hB0 + 32'(i), 32'(i));
    checkOutput("bp_drop", 32'(dropCnt), 32'd1);
    checkOutput("bp_err", 32'(errSeq), 32'd0);
    checkOutput("bp_rx_valid", 32'(rxValid), 32'd1);
    checkOutput("bp_head", rxToken, 32'hB1);
    idleCycles(3);
    #1;
    checkOutput("bp_ack_total", 32'(ackTotal), 32'd4);
    rxReady = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      idleCycles(1);
      checkOutput("bp_drain", rxToken, 32'hB0 + 32'(i));
    end
    idleCycles(1);
    checkOutput("bp_empty", 32'(rxValid), 32'd0);

    $display("[TB] alternating MINE/FOREIGN");
    applyReset();
    applyStimulus(1'b1, 32'd0, 32'hC1, 32'd1);
    checkOutput("alt_m1_wen", 32'(wenUp), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        applyStimulus(1'b1, 32'd0, 32'hC0 + 32'(k), 32'(k));
        checkOutput("alt_ack_id", idUp, 32'd0);
        checkOutput("alt_ack_credit", tokenUp, 32'd1);
      end
      applyStimulus(1'b1, 32'd7, 32'hF0 + 32'(k), 32'h100 + 32'(k));
      checkOutput("alt_fwd_wen", 32'(wenUp), 32'd1);
      checkOutput("alt_fwd_id", idUp, 32'd7);
      checkOutput("alt_fwd_token", tokenUp, 32'hF0 + 32'(k));
    end
    idleCycles(3);
    #1;
    checkOutput("alt_ack_total", 32'(ackTotal), 32'd3);

    $display("[TB] asynchronous reset mid-stream");
    rxReady = 1'b0;
    applyStimulus(1'b1, 32'd0, 32'hD1, 32'd50);
    applyStimulus(1'b1, 32'd9, 32'hD9, 32'd51);
    checkOutput("ar_pre_wen", 32'(wenUp), 32'd1);
    checkOutput("ar_pre_rx_valid", 32'(rxValid), 32'd1);
    #2;
    rstn = 1'b0;
    wenDown = 1'b0;
    #1;
    checkOutput("ar_wen", 32'(wenUp), 32'd0);
    checkOutput("ar_token", tokenUp, 32'd0);
    checkOutput("ar_id", idUp, 32'd0);
    checkOutput("ar_stamp", clkCntUp, 32'd0);
    checkOutput("ar_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("ar_rx_token", rxToken, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idleCycles(1);
    checkOutput("ar_post_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("ar_post_wen", 32'(wenUp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
